hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. Every cycle it decides whether the ID-stage control word is squashed into a bubble (`Hazard_o`, which drives the control-zeroing mux), whether PC and IF/ID advance, and whether IF/ID is flushed. It handles three cases: load-use interlock, taken-branch flush, and multi-cycle data-memory wait. The memory-wait case includes a timeout-to-error FSM and saturating performance counters.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/load_use_detect.sv | 17 +
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads the register an
// in-flight load in EX is about to write. x0 never creates a dependency.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs2,
  output logic       load_use
);

  assign load_use = mem_read & (rd != REG_ZERO) &
                    ((rd == rs1) | (uses_rs2 & (rd == rs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory wait with timeout-to-error, plus saturating stall/flush counters.
//
// state    | meaning
// RUN      | normal issue
// MEM_WAIT | data memory access outstanding
// ERROR    | memory timed out; left only by reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic [4:0]       IFID_Rs1_i,
  input  logic [4:0]       IFID_Rs2_i,
  input  logic             IFID_UsesRs2_i,
  input  logic             Branch_taken_i,
  input  logic             DMem_req_i,
  input  logic             DMem_ready_i,
  output logic             Hazard_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             MemStall_o,
  output logic             MemErr_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
  logic                mem_stall;
  logic                load_use;

  assign mem_stall = DMem_req_i & ~DMem_ready_i;

  load_use_detect u_load_use (
    .mem_read (IDEX_MemRead_i),
    .rd       (IDEX_Rd_i),
    .rs1      (IFID_Rs1_i),
    .rs2      (IFID_Rs2_i),
    .uses_rs2 (IFID_UsesRs2_i),
    .load_use (load_use)
  );

  // wait counter holds the number of stall cycles already completed in this
  // episode, so the first stall cycle (still in RUN) is counted on entry.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall)
          state_d = RUN;
        else if (wait_q == WAIT_LAST)
          state_d = ERROR;
        else
          wait_d = wait_q + WAIT_W'(1);
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    Hazard_o    = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    MemStall_o  = 1'b0;
    if (rst_i) begin
      Hazard_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (state_q == ERROR) begin
      Hazard_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      MemStall_o  = 1'b1;
    end else if (mem_stall) begin
      // EX is frozen, so any branch or load-use is re-presented after release
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      MemStall_o  = 1'b1;
    end else if (Branch_taken_i) begin
      Hazard_o    = 1'b1;
      IFIDFlush_o = 1'b1;
    end else if (load_use) begin
      Hazard_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end
  end

  assign MemErr_o = (state_q == ERROR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (IFIDFlush_o && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with a short timeout and narrow counters; directed
// scenarios followed by random traffic against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int T   = 4;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, memrd, us2, br, req, rdy;
  logic [4:0]    rd, rs1, rs2;
  logic          Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, MemStall_o, MemErr_o;
  logic [CW-1:0] StallCnt_o, FlushCnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  bit m_err   = 1'b0;
  int m_run   = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (memrd),
    .IDEX_Rd_i      (rd),
    .IFID_Rs1_i     (rs1),
    .IFID_Rs2_i     (rs2),
    .IFID_UsesRs2_i (us2),
    .Branch_taken_i (br),
    .DMem_req_i     (req),
    .DMem_ready_i   (rdy),
    .Hazard_o       (Hazard_o),
    .PCWrite_o      (PCWrite_o),
    .IFIDWrite_o    (IFIDWrite_o),
    .IFIDFlush_o    (IFIDFlush_o),
    .MemStall_o     (MemStall_o),
    .MemErr_o       (MemErr_o),
    .StallCnt_o     (StallCnt_o),
    .FlushCnt_o     (FlushCnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: drive, check against the model, clock, advance the model.
  task automatic step(input string tag, input logic r, input logic mr,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic b, input logic q, input logic y);
    logic [4:0] e;
    logic lu, ms;
    rst = r; memrd = mr; rd = d; rs1 = s1; rs2 = s2; us2 = u2; br = b; req = q; rdy = y;
    #2;
    lu = mr && (d != 5'd0) && ((d == s1) || (u2 && (d == s2)));
    ms = q && !y;
    // e = {hazard, pcwrite, ifidwrite, flush, memstall}
    if (r)          e = 5'b10000;
    else if (m_err) e = 5'b10001;
    else if (ms)    e = 5'b00001;
    else if (b)     e = 5'b11110;
    else if (lu)    e = 5'b10000;
    else            e = 5'b01100;
    chk({tag, ".ctl"}, 32'({Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, MemStall_o}), 32'(e));
    chk({tag, ".err"}, 32'(MemErr_o), 32'(m_err));
    chk({tag, ".stall_cnt"}, 32'(StallCnt_o), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(FlushCnt_o), 32'(m_flush));
    @(posedge clk);
    if (r) begin
      m_err = 1'b0; m_run = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[3] && m_stall < SAT) m_stall++;
      if (e[1] && m_flush < SAT) m_flush++;
      if (!m_err) begin
        if (ms) begin
          m_run++;
          if (m_run == T) m_err = 1'b1;
        end else begin
          m_run = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step("rst", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; memrd = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    us2 = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);

    idle("reset_state");

    step("load_use", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_lu", 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_stallcnt", 32'(StallCnt_o), 32'd1);

    step("x0_no_stall", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs2_unused", 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rs2_used", 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rs2_stallcnt", 32'(StallCnt_o), 32'd2);

    do_reset();
    step("br_over_lu", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("after_br");
    chk("br_flushcnt", 32'(FlushCnt_o), 32'd1);
    chk("br_stallcnt", 32'(StallCnt_o), 32'd0);

    do_reset();
    repeat (3) step("mem_wait", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("mem_ready", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("after_mem");
    chk("mem_stallcnt", 32'(StallCnt_o), 32'd3);
    chk("mem_flushcnt", 32'(FlushCnt_o), 32'd1);

    do_reset();
    repeat (3) step("edge_wait", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("edge_ready", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("after_edge");
    chk("edge_no_err", 32'(MemErr_o), 32'd0);

    do_reset();
    repeat (T) step("to_wait", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("to_err_set", 32'(MemErr_o), 32'd1);
    step("in_err", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("in_err_lu", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("err_cleared", 32'(MemErr_o), 32'd0);
    chk("err_cnt_clr", 32'(StallCnt_o), 32'd0);
    idle("after_err");

    do_reset();
    repeat (9) step("sat", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("after_sat");
    chk("sat_hold", 32'(StallCnt_o), 32'(SAT));

    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(24) == 0), 1'($urandom_range(1)),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom_range(1)), 1'($urandom_range(3) == 0),
           1'($urandom_range(1)), 1'($urandom_range(2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
